mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max wait cycles for dmem_ready before abort (range 1..255).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 valid_in  input  1  EX/MEM slot holds a valid instruction.
REQ-005 pc_in  input  64  branch target from EX/MEM.
REQ-006 zero_in, branch_in, memread_in, memwrite_in, memtoreg_in, regwrite_in  input  1 each  EX/MEM control bits.
REQ-007 alu_result_in  input  64  ALU result / memory address.
REQ-008 store_data_in  input  64  doubleword to store.
REQ-009 write_reg_in  input  5  destination register.
REQ-010 stall  output  1  upstream SHALL hold EX/MEM contents while high.
REQ-011 pcsrc  output  1  take branch; branch_target  output  64  equals pc_in.
REQ-012 dmem_req, dmem_we  output  1; dmem_addr, dmem_wdata  output  64; dmem_ready  input  1; dmem_rdata  input  64.
REQ-013 wb_valid, wb_memtoreg, wb_regwrite  output  1; wb_read_data, wb_alu_result  output  64; wb_write_reg  output  5  MEM/WB register.
REQ-014 err  output  1  one-cycle pulse on misalign or timeout.

Function
REQ-015 FSM states: IDLE, ACCESS.
REQ-016 mem_op = valid_in & (memread_in | memwrite_in); aligned = alu_result_in[2:0]==0.
REQ-017 pcsrc SHALL be valid_in & branch_in & zero_in, combinational, asserted only in IDLE.
REQ-018 IDLE, valid_in & !mem_op: MEM/WB SHALL load alu_result_in, write_reg_in, memtoreg_in, regwrite_in next edge, wb_valid=1 (latency 1).
REQ-019 IDLE, mem_op & aligned: latch address, store data, we=memwrite_in, control bits; go to ACCESS; stall=1 this cycle; wb_valid=0 next cycle.
REQ-020 IDLE, mem_op & !aligned: no request; err=1 next cycle; MEM/WB loads with wb_valid=1, wb_regwrite=0.
REQ-021 ACCESS: dmem_req=1, dmem_we/addr/wdata SHALL come from latches and stay stable until ready or abort.
REQ-022 ACCESS & dmem_ready: stall=0; next edge wb_read_data=dmem_rdata (loads; unchanged for stores), wb_valid=1, latched controls to MEM/WB, return to IDLE; min memory-op latency 2 cycles.
REQ-023 ACCESS & !dmem_ready: stall=1, wb_valid=0, 8-bit wait counter increments.
REQ-024 Counter reaching TIMEOUT_CYCLES without ready: drop dmem_req, IDLE, err=1 one cycle, wb_valid=0 (instruction discarded).
REQ-025 dmem_ready in the timeout cycle: ready wins, completes normally, no err.
REQ-026 wait counter clears on entry to ACCESS.
REQ-027 Outputs other than pcsrc, branch_target, stall SHALL be registered.
REQ-028 !valid_in in IDLE: bubble, wb_valid=0 next cycle, no request.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, dmem_req=0, dmem_we=0, err=0, wb_valid=0, wb_regwrite=0, wb_memtoreg=0, all data/address registers 0, wait counter 0.
REQ-030 Reset during ACCESS aborts the access without err; first post-reset cycle is IDLE.

Structure
REQ-031 Package mem_pkg SHALL hold the state enum, TIMEOUT_CYCLES default, XLEN=64, REG_ADDR_W=5.
REQ-032 MEM/WB register SHALL be a sub-module mem_wb_reg (clk, rst_n, load, bundle in/out); FSM, latches, counter stay in mem_stage.

Verification
REQ-033 ALU op, alu_result_in=0x10, write_reg_in=5, regwrite=1 -> next cycle wb_valid=1, wb_alu_result=0x10, wb_write_reg=5, stall never high.
REQ-034 Load addr 0x100, dmem_ready 3 cycles after req with rdata 0xDEAD -> stall high 4 cycles, dmem_addr=0x100 stable, then wb_read_data=0xDEAD, wb_valid=1.
REQ-035 Store addr 0x8, data 0x55, ready first ACCESS cycle -> dmem_we=1, dmem_wdata=0x55, wb_valid=1 after 2 cycles, wb_regwrite=0.
REQ-036 Load addr 0x103 -> no dmem_req, err pulse, wb_valid=1, wb_regwrite=0.
REQ-037 TIMEOUT_CYCLES=4, dmem_ready never -> dmem_req drops after 4 wait cycles, err 1 cycle, wb_valid=0; repeat with ready in 4th cycle -> completes, no err.
REQ-038 branch_in=1, zero_in=1, pc_in=0x40 -> pcsrc=1, branch_target=0x40 same cycle; rst_n low mid-ACCESS -> dmem_req=0 without clock edge.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM state,
// MEM/WB bundle layout and datapath widths.
package mem_pkg;

   localparam int XLEN                   = 64;
   localparam int REG_ADDR_W             = 5;
   localparam int TIMEOUT_CYCLES_DEFAULT = 255;
   localparam int WAIT_CNT_W             = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic                  valid;
      logic                  memtoreg;
      logic                  regwrite;
      logic [XLEN-1:0]       read_data;
      logic [XLEN-1:0]       alu_result;
      logic [REG_ADDR_W-1:0] write_reg;
   } wb_bundle_t;

   // Doubleword accesses only: the low three address bits must be clear.
   function automatic logic is_aligned(input logic [XLEN-1:0] addr);
      return addr[2:0] == 3'b000;
   endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A cycle without load keeps the payload but
// drops valid, so the write-back stage sees a bubble.
module mem_wb_reg
   import mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  wb_bundle_t bundle_in,
   output wb_bundle_t bundle_out
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bundle_out <= '0;
      end else if (load) begin
         bundle_out <= bundle_in;
      end else begin
         bundle_out.valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, data-memory handshake with
// misalign/timeout aborts, and the MEM/WB register.
module mem_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   input  logic [XLEN-1:0]       pc_in,
   input  logic                  zero_in,
   input  logic                  branch_in,
   input  logic                  memread_in,
   input  logic                  memwrite_in,
   input  logic                  memtoreg_in,
   input  logic                  regwrite_in,
   input  logic [XLEN-1:0]       alu_result_in,
   input  logic [XLEN-1:0]       store_data_in,
   input  logic [REG_ADDR_W-1:0] write_reg_in,
   output logic                  stall,
   output logic                  pcsrc,
   output logic [XLEN-1:0]       branch_target,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [XLEN-1:0]       dmem_addr,
   output logic [XLEN-1:0]       dmem_wdata,
   input  logic                  dmem_ready,
   input  logic [XLEN-1:0]       dmem_rdata,
   output logic                  wb_valid,
   output logic                  wb_memtoreg,
   output logic                  wb_regwrite,
   output logic [XLEN-1:0]       wb_read_data,
   output logic [XLEN-1:0]       wb_alu_result,
   output logic [REG_ADDR_W-1:0] wb_write_reg,
   output logic                  err
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_t            state;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  lat_memread;
   logic                  lat_memtoreg;
   logic                  lat_regwrite;
   logic [REG_ADDR_W-1:0] lat_write_reg;

   logic       mem_op;
   logic       aligned;
   logic       timeout;
   logic       wb_load;
   wb_bundle_t wb_d;
   wb_bundle_t wb_q;

   assign mem_op        = valid_in & (memread_in | memwrite_in);
   assign aligned       = is_aligned(alu_result_in);
   assign timeout       = (state == ACCESS) & ~dmem_ready & (wait_cnt == WAIT_LIMIT);
   assign pcsrc         = (state == IDLE) & valid_in & branch_in & zero_in;
   assign branch_target = pc_in;

   // The abort cycle releases the stall so the discarded instruction drains
   // out of EX/MEM instead of being re-issued.
   always_comb begin
      stall = 1'b0;
      case (state)
         IDLE:    stall = mem_op & aligned;
         ACCESS:  stall = ~dmem_ready & ~timeout;
         default: stall = 1'b0;
      endcase
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      wb_load = 1'b0;
      wb_d       = wb_q;
      wb_d.valid = 1'b1;
      case (state)
         IDLE: begin
            if (valid_in && !(mem_op && aligned)) begin
               wb_load         = 1'b1;
               wb_d.alu_result = alu_result_in;
               wb_d.write_reg  = write_reg_in;
               wb_d.memtoreg   = memtoreg_in;
               wb_d.regwrite   = regwrite_in & ~mem_op;
            end
         end
         ACCESS: begin
            if (dmem_ready) begin
               wb_load         = 1'b1;
               wb_d.alu_result = dmem_addr;
               wb_d.write_reg  = lat_write_reg;
               wb_d.memtoreg   = lat_memtoreg;
               wb_d.regwrite   = lat_regwrite;
               wb_d.read_data  = lat_memread ? dmem_rdata : wb_q.read_data;
            end
         end
         default: wb_load = 1'b0;
      endcase
   end

   // NOTE: the address/data latches are plain flops, not a memory array, so
   // they take the async reset like the control state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         lat_memread   <= 1'b0;
         lat_memtoreg  <= 1'b0;
         lat_regwrite  <= 1'b0;
         lat_write_reg <= '0;
         err           <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_op) begin
                  if (aligned) begin
                     state         <= ACCESS;
                     wait_cnt      <= '0;
                     dmem_req      <= 1'b1;
                     dmem_we       <= memwrite_in;
                     dmem_addr     <= alu_result_in;
                     dmem_wdata    <= store_data_in;
                     lat_memread   <= memread_in;
                     lat_memtoreg  <= memtoreg_in;
                     lat_regwrite  <= regwrite_in;
                     lat_write_reg <= write_reg_in;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               // Ready is tested first so it wins in the timeout cycle.
               if (dmem_ready) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
               end else if (timeout) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  err      <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mem_wb_reg u_mem_wb_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (wb_load),
      .bundle_in  (wb_d),
      .bundle_out (wb_q)
   );

   assign wb_valid      = wb_q.valid;
   assign wb_memtoreg   = wb_q.memtoreg;
   assign wb_regwrite   = wb_q.regwrite;
   assign wb_read_data  = wb_q.read_data;
   assign wb_alu_result = wb_q.alu_result;
   assign wb_write_reg  = wb_q.write_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table-driven single-cycle ops plus
// hand-written load/store/misalign/timeout/reset sequences, MEM/WB scoreboard.
module tb_mem_stage;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in, zero_in, branch_in, memread_in, memwrite_in, memtoreg_in, regwrite_in;
   logic [63:0] pc_in, alu_result_in, store_data_in;
   logic [4:0]  write_reg_in;
   logic        stall, pcsrc;
   logic [63:0] branch_target;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        wb_valid, wb_memtoreg, wb_regwrite, err;
   logic [63:0] wb_read_data, wb_alu_result;
   logic [4:0]  wb_write_reg;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in),
      .zero_in(zero_in), .branch_in(branch_in), .memread_in(memread_in),
      .memwrite_in(memwrite_in), .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in),
      .write_reg_in(write_reg_in), .stall(stall), .pcsrc(pcsrc),
      .branch_target(branch_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg),
      .wb_regwrite(wb_regwrite), .wb_read_data(wb_read_data),
      .wb_alu_result(wb_alu_result), .wb_write_reg(wb_write_reg), .err(err)
   );

   typedef struct {
      logic [63:0] alu;
      logic [4:0]  rg;
      logic        m2r;
      logic        rw;
      logic [63:0] rdata;
   } wb_exp_t;

   typedef struct {
      logic        v;
      logic        br;
      logic        z;
      logic        m2r;
      logic        rw;
      logic [63:0] alu;
      logic [63:0] pc;
      logic [4:0]  rg;
      logic        exp_pcsrc;
   } vec_t;

   wb_exp_t     sb[$];
   vec_t        vecs[6];
   logic [63:0] model_rdata;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                        input logic rw, input logic br, input logic z,
                        input logic [63:0] alu, input logic [63:0] sd,
                        input logic [63:0] pc, input logic [4:0] rg);
      valid_in = v; memread_in = rd; memwrite_in = wr; memtoreg_in = m2r;
      regwrite_in = rw; branch_in = br; zero_in = z; alu_result_in = alu;
      store_data_in = sd; pc_in = pc; write_reg_in = rg;
   endtask

   task automatic bubble();
      drive(0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 5'd0);
   endtask

   task automatic push(input logic [63:0] alu, input logic [4:0] rg, input logic m2r,
                       input logic rw, input logic [63:0] rdata);
      wb_exp_t e;
      e.alu = alu; e.rg = rg; e.m2r = m2r; e.rw = rw; e.rdata = rdata;
      sb.push_back(e);
   endtask

   task automatic cycle_start();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every valid MEM/WB output must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("wb_unexpected_valid", 64'(wb_valid), 64'd0);
         end else begin
            wb_exp_t e;
            e = sb.pop_front();
            check("wb_alu_result", wb_alu_result, e.alu);
            check("wb_write_reg", 64'(wb_write_reg), 64'(e.rg));
            check("wb_memtoreg", 64'(wb_memtoreg), 64'(e.m2r));
            check("wb_regwrite", 64'(wb_regwrite), 64'(e.rw));
            check("wb_read_data", wb_read_data, e.rdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int stall_cnt;

      vecs[0] = '{v:1, br:0, z:0, m2r:0, rw:1, alu:64'h10, pc:64'h0, rg:5'd5, exp_pcsrc:0};
      vecs[1] = '{v:1, br:1, z:1, m2r:0, rw:0, alu:64'h0, pc:64'h40, rg:5'd0, exp_pcsrc:1};
      vecs[2] = '{v:1, br:1, z:0, m2r:0, rw:1, alu:64'h1, pc:64'h80, rg:5'd2, exp_pcsrc:0};
      vecs[3] = '{v:0, br:1, z:1, m2r:0, rw:1, alu:64'h33, pc:64'hC0, rg:5'd3, exp_pcsrc:0};
      vecs[4] = '{v:1, br:0, z:1, m2r:0, rw:1, alu:64'hFFFF_FFFF_FFFF_FFF8, pc:64'h0, rg:5'd31, exp_pcsrc:0};
      vecs[5] = '{v:1, br:0, z:0, m2r:1, rw:0, alu:64'h7, pc:64'h0, rg:5'd1, exp_pcsrc:0};

      rst_n = 1'b0; dmem_ready = 1'b0; dmem_rdata = 64'h0; model_rdata = 64'h0;
      bubble();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_dmem_req", 64'(dmem_req), 64'd0);
      check("rst_dmem_we", 64'(dmem_we), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_wb_regwrite", 64'(wb_regwrite), 64'd0);
      check("rst_wb_read_data", wb_read_data, 64'd0);
      check("rst_dmem_addr", dmem_addr, 64'd0);
      cycle_start();
      rst_n = 1'b1;

      // Single-cycle ALU / branch / bubble table.
      for (int i = 0; i < 6; i++) begin
         cycle_start();
         drive(vecs[i].v, 0, 0, vecs[i].m2r, vecs[i].rw, vecs[i].br, vecs[i].z,
               vecs[i].alu, 64'h0, vecs[i].pc, vecs[i].rg);
         if (vecs[i].v) push(vecs[i].alu, vecs[i].rg, vecs[i].m2r, vecs[i].rw, model_rdata);
         @(negedge clk);
         check($sformatf("vec%0d_pcsrc", i), 64'(pcsrc), 64'(vecs[i].exp_pcsrc));
         check($sformatf("vec%0d_branch_target", i), branch_target, vecs[i].pc);
         check($sformatf("vec%0d_stall", i), 64'(stall), 64'd0);
         check($sformatf("vec%0d_dmem_req", i), 64'(dmem_req), 64'd0);
         check($sformatf("vec%0d_err", i), 64'(err), 64'd0);
      end
      cycle_start();
      bubble();

      // Load at 0x100, ready on the fourth ACCESS cycle.
      cycle_start();
      drive(1, 1, 0, 1, 1, 0, 0, 64'h100, 64'h0, 64'h0, 5'd7);
      push(64'h100, 5'd7, 1, 1, 64'hDEAD);
      model_rdata = 64'hDEAD;
      stall_cnt = 0;
      @(negedge clk);
      if (stall) stall_cnt++;
      check("ld_req_not_yet", 64'(dmem_req), 64'd0);
      for (int c = 1; c <= 4; c++) begin
         cycle_start();
         dmem_ready = (c == 4);
         dmem_rdata = (c == 4) ? 64'hDEAD : 64'hBAD0;
         @(negedge clk);
         if (stall) stall_cnt++;
         check($sformatf("ld_req_c%0d", c), 64'(dmem_req), 64'd1);
         check($sformatf("ld_addr_c%0d", c), dmem_addr, 64'h100);
         check($sformatf("ld_we_c%0d", c), 64'(dmem_we), 64'd0);
      end
      check("ld_stall_cycles", 64'(stall_cnt), 64'd4);
      cycle_start();
      dmem_ready = 1'b0;
      bubble();
      @(negedge clk);
      check("ld_wb_valid", 64'(wb_valid), 64'd1);
      check("ld_req_dropped", 64'(dmem_req), 64'd0);
      check("ld_err", 64'(err), 64'd0);

      // Store at 0x8, ready on the first ACCESS cycle.
      cycle_start();
      drive(1, 0, 1, 0, 0, 0, 0, 64'h8, 64'h55, 64'h0, 5'd3);
      push(64'h8, 5'd3, 0, 0, model_rdata);
      @(negedge clk);
      check("st_stall_idle", 64'(stall), 64'd1);
      cycle_start();
      dmem_ready = 1'b1;
      dmem_rdata = 64'h1234;
      @(negedge clk);
      check("st_req", 64'(dmem_req), 64'd1);
      check("st_we", 64'(dmem_we), 64'd1);
      check("st_wdata", dmem_wdata, 64'h55);
      check("st_addr", dmem_addr, 64'h8);
      check("st_stall_ready", 64'(stall), 64'd0);
      cycle_start();
      dmem_ready = 1'b0;
      bubble();
      @(negedge clk);
      check("st_wb_valid", 64'(wb_valid), 64'd1);

      // Misaligned load at 0x103.
      cycle_start();
      drive(1, 1, 0, 1, 1, 0, 0, 64'h103, 64'h0, 64'h0, 5'd9);
      push(64'h103, 5'd9, 1, 0, model_rdata);
      @(negedge clk);
      check("mis_stall", 64'(stall), 64'd0);
      cycle_start();
      bubble();
      @(negedge clk);
      check("mis_err", 64'(err), 64'd1);
      check("mis_no_req", 64'(dmem_req), 64'd0);
      check("mis_wb_valid", 64'(wb_valid), 64'd1);
      cycle_start();
      @(negedge clk);
      check("mis_err_pulse_end", 64'(err), 64'd0);

      // Timeout: ready never arrives.
      cycle_start();
      drive(1, 1, 0, 1, 1, 0, 0, 64'h200, 64'h0, 64'h0, 5'd4);
      for (int c = 1; c <= TMO; c++) begin
         cycle_start();
         @(negedge clk);
         check($sformatf("to_req_c%0d", c), 64'(dmem_req), 64'd1);
         check($sformatf("to_err_c%0d", c), 64'(err), 64'd0);
      end
      cycle_start();
      bubble();
      @(negedge clk);
      check("to_req_dropped", 64'(dmem_req), 64'd0);
      check("to_err", 64'(err), 64'd1);
      check("to_wb_valid", 64'(wb_valid), 64'd0);
      cycle_start();
      @(negedge clk);
      check("to_err_pulse_end", 64'(err), 64'd0);

      // Ready exactly in the timeout cycle wins.
      cycle_start();
      drive(1, 1, 0, 1, 1, 0, 0, 64'h208, 64'h0, 64'h0, 5'd4);
      push(64'h208, 5'd4, 1, 1, 64'hBEEF);
      model_rdata = 64'hBEEF;
      for (int c = 1; c <= TMO; c++) begin
         cycle_start();
         dmem_ready = (c == TMO);
         dmem_rdata = 64'hBEEF;
         @(negedge clk);
         check($sformatf("tr_req_c%0d", c), 64'(dmem_req), 64'd1);
      end
      cycle_start();
      dmem_ready = 1'b0;
      bubble();
      @(negedge clk);
      check("tr_no_err", 64'(err), 64'd0);
      check("tr_wb_valid", 64'(wb_valid), 64'd1);

      // Asynchronous reset in the middle of an access.
      cycle_start();
      drive(1, 1, 0, 1, 1, 0, 0, 64'h300, 64'h0, 64'h0, 5'd8);
      cycle_start();
      @(negedge clk);
      check("rs_req_before", 64'(dmem_req), 64'd1);
      #2;
      rst_n = 1'b0;
      bubble();
      #1;
      check("rs_req_async", 64'(dmem_req), 64'd0);
      check("rs_err", 64'(err), 64'd0);
      check("rs_wb_valid", 64'(wb_valid), 64'd0);
      model_rdata = 64'h0;
      cycle_start();
      rst_n = 1'b1;
      @(negedge clk);
      check("rs_post_req", 64'(dmem_req), 64'd0);
      check("rs_post_err", 64'(err), 64'd0);

      // First instruction after reset is handled from IDLE.
      cycle_start();
      drive(1, 0, 0, 0, 1, 0, 0, 64'h20, 64'h0, 64'h0, 5'd6);
      push(64'h20, 5'd6, 0, 1, model_rdata);
      @(negedge clk);
      check("rs_idle_stall", 64'(stall), 64'd0);
      cycle_start();
      bubble();
      repeat (2) cycle_start();
      @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
